// File: rtl/interrupt_controller.sv
// ---------------------------------------------------------------------------
// interrupt_controller
//
// Memory-mapped interrupt controller. Collects NUM_SRC level interrupt lines
// (bit 0 is the timer), edge-detects them into pending latches, gates them
// with a software mask and presents one IRQ to the CPU. The lowest eligible
// index wins. A claim (read of CLAIM) / complete (write of COMPLETE)
// handshake keeps exactly one interrupt in service at a time.
//
// Register map (byte offsets from BASE_ADDR):
//   +0x00 PENDING   read pending bits, write-1-to-clear
//   +0x08 MASK      read/write, 1 = source enabled
//   +0x10 CLAIM     read-only, claims the winning id (all ones if none)
//   +0x18 COMPLETE  write-only, ends service of the claimed id; reads 0
//
// Ports:
//   clock      in   system clock, rising edge
//   reset      in   asynchronous active-high reset
//   irq_src    in   [NUM_SRC]  level interrupt lines (bit 0 = timer)
//   address    in   [width]    bus address
//   data       in   [width]    bus write data
//   MemRead    in   bus read strobe
//   MemWrite   in   bus write strobe
//   rdata      out  [width]    read data, zero unless MemRead and ICAddress
//   ICAddress  out  high when address hits one of the four registers
//   IRQ        out  interrupt request to the CPU
// ---------------------------------------------------------------------------
module interrupt_controller #(
    parameter int unsigned           width     = 64,
    parameter int unsigned           NUM_SRC   = 8,
    parameter logic [width-1:0]      BASE_ADDR = 64'hFFFF0080
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [NUM_SRC-1:0]   irq_src,
    input  logic [width-1:0]     address,
    input  logic [width-1:0]     data,
    input  logic                 MemRead,
    input  logic                 MemWrite,
    output logic [width-1:0]     rdata,
    output logic                 ICAddress,
    output logic                 IRQ
);

    localparam int unsigned ID_W = $clog2(NUM_SRC);

    localparam logic [width-1:0] A_PENDING  = BASE_ADDR;
    localparam logic [width-1:0] A_MASK     = BASE_ADDR + width'(8);
    localparam logic [width-1:0] A_CLAIM    = BASE_ADDR + width'(16);
    localparam logic [width-1:0] A_COMPLETE = BASE_ADDR + width'(24);

    typedef enum logic {
        IDLE,
        SERVICING
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t               r_state;
    state_t               w_state_next;
    logic [NUM_SRC-1:0]   r_pending;
    logic [NUM_SRC-1:0]   r_mask;
    logic [NUM_SRC-1:0]   r_src_prev;
    logic [ID_W-1:0]      r_in_service_id;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic w_sel_pending;
    logic w_sel_mask;
    logic w_sel_claim;
    logic w_sel_complete;

    assign w_sel_pending  = (address == A_PENDING);
    assign w_sel_mask     = (address == A_MASK);
    assign w_sel_claim    = (address == A_CLAIM);
    assign w_sel_complete = (address == A_COMPLETE);
    assign ICAddress      = w_sel_pending | w_sel_mask | w_sel_claim | w_sel_complete;

    // ------------------------------------------------------------------
    // Priority selection: lowest eligible index wins
    // ------------------------------------------------------------------
    logic [NUM_SRC-1:0]   w_eligible;
    logic                 w_any;
    logic                 w_found;
    logic [ID_W-1:0]      w_winner;

    assign w_eligible = r_pending & r_mask;
    assign w_any      = |w_eligible;

    always_comb begin
        w_winner = '0;
        w_found  = 1'b0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (!w_found && w_eligible[i]) begin
                w_winner = ID_W'(i);
                w_found  = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Bus events
    // ------------------------------------------------------------------
    logic w_claim;
    logic w_complete;
    logic w_wr_pending;
    logic w_wr_mask;

    // A claim only has side effects when something is actually eligible
    // and no interrupt is already in service.
    assign w_claim      = MemRead && w_sel_claim && (r_state == IDLE) && w_any;

    // Comparing the full bus word against the zero-extended id also
    // requires every bit above the id field to be zero.
    assign w_complete   = MemWrite && w_sel_complete && (r_state == SERVICING) &&
                          (data == width'(r_in_service_id));

    assign w_wr_pending = MemWrite && w_sel_pending;
    assign w_wr_mask    = MemWrite && w_sel_mask;

    // ------------------------------------------------------------------
    // Pending latch update: clears first, then new edges, so a fresh edge
    // in the same cycle as a W1C or claim leaves the bit set.
    // ------------------------------------------------------------------
    logic [NUM_SRC-1:0] w_set;
    logic [NUM_SRC-1:0] w_clr;
    logic [NUM_SRC-1:0] w_pending_next;

    always_comb begin
        w_set = irq_src & ~r_src_prev;
        w_clr = '0;
        if (w_wr_pending) begin
            w_clr = w_clr | data[NUM_SRC-1:0];
        end
        if (w_claim) begin
            w_clr = w_clr | (NUM_SRC'(1) << w_winner);
        end
        w_pending_next = (r_pending & ~w_clr) | w_set;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_pending  <= '0;
            r_src_prev <= '0;
            r_mask     <= '0;
        end else begin
            r_pending  <= w_pending_next;
            r_src_prev <= irq_src;
            if (w_wr_mask) begin
                r_mask <= data[NUM_SRC-1:0];
            end
        end
    end

    // ------------------------------------------------------------------
    // Service FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state         <= IDLE;
            r_in_service_id <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_claim) begin
                r_in_service_id <= w_winner;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        IRQ          = 1'b0;
        unique case (r_state)
            IDLE: begin
                IRQ = w_any;
                if (w_claim) begin
                    w_state_next = SERVICING;
                end
            end
            SERVICING: begin
                if (w_complete) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Read data: combinational from current registers, so a simultaneous
    // read and write of one register returns the pre-edge value.
    // ------------------------------------------------------------------
    always_comb begin
        rdata = '0;
        if (MemRead) begin
            if (w_sel_pending) begin
                rdata = width'(r_pending);
            end else if (w_sel_mask) begin
                rdata = width'(r_mask);
            end else if (w_sel_claim) begin
                rdata = ((r_state == IDLE) && w_any) ? width'(w_winner) : '1;
            end
        end
    end

endmodule

// File: tb/tb_interrupt_controller.sv
module tb_interrupt_controller;

    localparam logic [63:0] BASE   = 64'hFFFF0080;
    localparam logic [63:0] A_PEND = BASE;
    localparam logic [63:0] A_MASK = BASE + 64'h08;
    localparam logic [63:0] A_CLM  = BASE + 64'h10;
    localparam logic [63:0] A_CMP  = BASE + 64'h18;
    localparam logic [63:0] ONES   = 64'hFFFF_FFFF_FFFF_FFFF;

    logic        clock;
    logic        reset;
    logic [7:0]  irq_src;
    logic [63:0] address;
    logic [63:0] data;
    logic        MemRead;
    logic        MemWrite;
    logic [63:0] rdata;
    logic        ICAddress;
    logic        IRQ;

    interrupt_controller #(
        .width     (64),
        .NUM_SRC   (8),
        .BASE_ADDR (64'hFFFF0080)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .irq_src   (irq_src),
        .address   (address),
        .data      (data),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .rdata     (rdata),
        .ICAddress (ICAddress),
        .IRQ       (IRQ)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        string       name;
        logic [63:0] val;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        e;
    logic [63:0] got;
    int          n_checks = 0;
    int          n_errors = 0;

    // Bus read: address presented at negedge, data sampled 1ns later,
    // side effects land on the following posedge.
    task automatic bus_read(input logic [63:0] a, output logic [63:0] d);
        @(negedge clock);
        address = a;
        MemRead = 1'b1;
        #1 d = rdata;
        @(posedge clock);
        #1;
        MemRead = 1'b0;
        address = '0;
    endtask

    task automatic bus_write(input logic [63:0] a, input logic [63:0] v);
        @(negedge clock);
        address  = a;
        data     = v;
        MemWrite = 1'b1;
        @(posedge clock);
        #1;
        MemWrite = 1'b0;
        address  = '0;
        data     = '0;
    endtask

    // One-cycle pulse; pending latches on the posedge inside the pulse.
    task automatic pulse_src(input logic [7:0] v);
        @(negedge clock);
        irq_src = v;
        @(negedge clock);
        irq_src = '0;
    endtask

    task automatic test_reset;
        exp_q.push_back('{"rst_irq", 64'd0});
        #1 got = 64'(IRQ);
        e = exp_q.pop_front(); n_checks++;
        if (got !== e.val) begin n_errors++; $display("FAIL %s: got=%h expected=%h", e.name, got, e.val); end
        @(negedge clock);
        reset = 1'b0;
        exp_q.push_back('{"rst_pending", 64'd0});
        bus_read(A_PEND, got);
        e = exp_q.pop_front(); n_checks++;
        if (got !== e.val) begin n_errors++; $display("FAIL %s: got=%h expected=%h", e.name, got, e.val); end
        exp_q.push_back('{"rst_mask", 64'd0});
        bus_read(A_MASK, got);
        e = exp_q.pop_front(); n_checks++;
        if (got !== e.val) begin n_errors++; $display("FAIL %s: got=%h expected=%h", e.name, got, e.val); end
        exp_q.push_back('{"rst_icaddr_off", 64'd0});
        address = BASE + 64'h20;
        #1 got = 64'(ICAddress);
        address = '0;
        e = exp_q.pop_front(); n_checks++;
        if (got !== e.val) begin n_errors++; $display("FAIL %s: got=%h expected=%h", e.name, got, e.val); end
    endtask

    task automatic test_masked_w1c;
        pulse_src(8'h01);
        exp_q.push_back('{"masked_irq", 64'd0});
        #1 got = 64'(IRQ);
        e = exp_q.pop_front(); n_checks++;
        if (got !== e.val) begin n_errors++; $display("FAIL %s: got=%h expected=%h", e.name, got, e.val); end
        exp_q.push_back('{"masked_pending", 64'h1});
        bus_read(A_PEND, got);
        e = exp_q.pop_front(); n_checks++;
        if (got !== e.val) begin n_errors++; $display("FAIL %s: got=%h expected=%h", e.name, got, e.val); end
        // read and W1C of PENDING in one access: pre-edge value returned
        exp_q.push_back('{"rw_same_reg", 64'h1});
        @(negedge clock);
        address = A_PEND; data = 64'h1; MemRead = 1'b1; MemWrite = 1'b1;
        #1 got = rdata;
        @(posedge clock);
        #1 MemRead = 1'b0; MemWrite = 1'b0; address = '0; data = '0;
        e = exp_q.pop_front(); n_checks++;
        if (got !== e.val) begin n_errors++; $display("FAIL %s: got=%h expected=%h", e.name, got, e.val); end
        exp_q.push_back('{"w1c_pending", 64'h0});
        bus_read(A_PEND, got);
        e = exp_q.pop_front(); n_checks++;
        if (got !== e.val) begin n_errors++; $display("FAIL %s: got=%h expected=%h", e.name, got, e.val); end
    endtask

    task automatic test_timer_claim;
        bus_write(A_MASK, 64'h01);
        @(negedge clock);
        irq_src = 8'h01;
        exp_q.push_back('{"timer_irq_before", 64'd0});
        #1 got = 64'(IRQ);
        e = exp_q.pop_front(); n_checks++;
        if (got !== e.val) begin n_errors++; $display("FAIL %s: got=%h expected=%h", e.name, got, e.val); end
        exp_q.push_back('{"timer_irq_rise", 64'd1});
        @(posedge clock);
        #1 got = 64'(IRQ);
        e = exp_q.pop_front(); n_checks++;
        if (got !== e.val) begin n_errors++; $display("FAIL %s: got=%h expected=%h", e.name, got, e.val); end
        @(negedge clock);
        irq_src = '0;
        exp_q.push_back('{"timer_claim", 64'd0});
        bus_read(A_CLM, got);
        e = exp_q.pop_front(); n_checks++;
        if (got !== e.val) begin n_errors++; $display("FAIL %s: got=%h expected=%h", e.name, got, e.val); end
        exp_q.push_back('{"timer_irq_svc", 64'd0});
        got = 64'(IRQ);
        e = exp_q.pop_front(); n_checks++;
        if (got !== e.val) begin n_errors++; $display("FAIL %s: got=%h expected=%h", e.name, got, e.val); end
        exp_q.push_back('{"timer_pending_clr", 64'd0});
        bus_read(A_PEND, got);
        e = exp_q.pop_front(); n_checks++;
        if (got !== e.val) begin n_errors++; $display("FAIL %s: got=%h expected=%h", e.name, got, e.val); end
        bus_write(A_CMP, 64'd0);
        exp_q.push_back('{"timer_irq_done", 64'd0});
        got = 64'(IRQ);
        e = exp_q.pop_front(); n_checks++;
        if (got !== e.val) begin n_errors++; $display("FAIL %s: got=%h expected=%h", e.name, got, e.val); end
        exp_q.push_back('{"idle_claim_empty", ONES});
        bus_read(A_CLM, got);
        e = exp_q.pop_front(); n_checks++;
        if (got !== e.val) begin n_errors++; $display("FAIL %s: got=%h expected=%h", e.name, got, e.val); end
    endtask

    task automatic test_priority;
        bus_write(A_MASK, 64'hFF);
        pulse_src(8'h0A);
        exp_q.push_back('{"prio_claim_1", 64'd1});
        bus_read(A_CLM, got);
        e = exp_q.pop_front(); n_checks++;
        if (got !== e.val) begin n_errors++; $display("FAIL %s: got=%h expected=%h", e.name, got, e.val); end
        exp_q.push_back('{"prio_irq_svc", 64'd0});
        got = 64'(IRQ);
        e = exp_q.pop_front(); n_checks++;
        if (got !== e.val) begin n_errors++; $display("FAIL %s: got=%h expected=%h", e.name, got, e.val); end
        bus_write(A_CMP, 64'd1);
        exp_q.push_back('{"prio_irq_again", 64'd1});
        got = 64'(IRQ);
        e = exp_q.pop_front(); n_checks++;
        if (got !== e.val) begin n_errors++; $display("FAIL %s: got=%h expected=%h", e.name, got, e.val); end
        exp_q.push_back('{"prio_claim_3", 64'd3});
        bus_read(A_CLM, got);
        e = exp_q.pop_front(); n_checks++;
        if (got !== e.val) begin n_errors++; $display("FAIL %s: got=%h expected=%h", e.name, got, e.val); end
        bus_write(A_CMP, 64'd3);
        exp_q.push_back('{"prio_irq_end", 64'd0});
        got = 64'(IRQ);
        e = exp_q.pop_front(); n_checks++;
        if (got !== e.val) begin n_errors++; $display("FAIL %s: got=%h expected=%h", e.name, got, e.val); end
        exp_q.push_back('{"prio_pending_end", 64'd0});
        bus_read(A_PEND, got);
        e = exp_q.pop_front(); n_checks++;
        if (got !== e.val) begin n_errors++; $display("FAIL %s: got=%h expected=%h", e.name, got, e.val); end
    endtask

    task automatic test_bad_complete;
        pulse_src(8'h04);
        exp_q.push_back('{"svc_claim_2", 64'd2});
        bus_read(A_CLM, got);
        e = exp_q.pop_front(); n_checks++;
        if (got !== e.val) begin n_errors++; $display("FAIL %s: got=%h expected=%h", e.name, got, e.val); end
        pulse_src(8'h10);
        bus_write(A_CMP, 64'd5);
        bus_write(A_CMP, 64'h1_0000_0002);
        exp_q.push_back('{"svc_claim_busy", ONES});
        bus_read(A_CLM, got);
        e = exp_q.pop_front(); n_checks++;
        if (got !== e.val) begin n_errors++; $display("FAIL %s: got=%h expected=%h", e.name, got, e.val); end
        exp_q.push_back('{"svc_irq_busy", 64'd0});
        got = 64'(IRQ);
        e = exp_q.pop_front(); n_checks++;
        if (got !== e.val) begin n_errors++; $display("FAIL %s: got=%h expected=%h", e.name, got, e.val); end
        exp_q.push_back('{"complete_reads_0", 64'd0});
        bus_read(A_CMP, got);
        e = exp_q.pop_front(); n_checks++;
        if (got !== e.val) begin n_errors++; $display("FAIL %s: got=%h expected=%h", e.name, got, e.val); end
        exp_q.push_back('{"svc_pending_latched", 64'h10});
        bus_read(A_PEND, got);
        e = exp_q.pop_front(); n_checks++;
        if (got !== e.val) begin n_errors++; $display("FAIL %s: got=%h expected=%h", e.name, got, e.val); end
        bus_write(A_CMP, 64'd2);
        exp_q.push_back('{"svc_claim_4", 64'd4});
        bus_read(A_CLM, got);
        e = exp_q.pop_front(); n_checks++;
        if (got !== e.val) begin n_errors++; $display("FAIL %s: got=%h expected=%h", e.name, got, e.val); end
        bus_write(A_CMP, 64'd4);
        // masked pending fires once unmasked
        bus_write(A_MASK, 64'h00);
        pulse_src(8'h20);
        exp_q.push_back('{"unmask_irq_low", 64'd0});
        #1 got = 64'(IRQ);
        e = exp_q.pop_front(); n_checks++;
        if (got !== e.val) begin n_errors++; $display("FAIL %s: got=%h expected=%h", e.name, got, e.val); end
        bus_write(A_MASK, 64'hFF);
        exp_q.push_back('{"unmask_irq_high", 64'd1});
        got = 64'(IRQ);
        e = exp_q.pop_front(); n_checks++;
        if (got !== e.val) begin n_errors++; $display("FAIL %s: got=%h expected=%h", e.name, got, e.val); end
        exp_q.push_back('{"unmask_claim_5", 64'd5});
        bus_read(A_CLM, got);
        e = exp_q.pop_front(); n_checks++;
        if (got !== e.val) begin n_errors++; $display("FAIL %s: got=%h expected=%h", e.name, got, e.val); end
        bus_write(A_CMP, 64'd5);
    endtask

    task automatic test_claim_set_collision;
        pulse_src(8'h01);
        // claim of id 0 on the same edge as a fresh rise of irq_src[0]
        exp_q.push_back('{"coll_claim_0", 64'd0});
        @(negedge clock);
        address = A_CLM; MemRead = 1'b1; irq_src = 8'h01;
        #1 got = rdata;
        @(posedge clock);
        #1 MemRead = 1'b0; address = '0;
        e = exp_q.pop_front(); n_checks++;
        if (got !== e.val) begin n_errors++; $display("FAIL %s: got=%h expected=%h", e.name, got, e.val); end
        @(negedge clock);
        irq_src = '0;
        exp_q.push_back('{"coll_pending", 64'h1});
        bus_read(A_PEND, got);
        e = exp_q.pop_front(); n_checks++;
        if (got !== e.val) begin n_errors++; $display("FAIL %s: got=%h expected=%h", e.name, got, e.val); end
        bus_write(A_CMP, 64'd0);
        exp_q.push_back('{"coll_irq", 64'd1});
        got = 64'(IRQ);
        e = exp_q.pop_front(); n_checks++;
        if (got !== e.val) begin n_errors++; $display("FAIL %s: got=%h expected=%h", e.name, got, e.val); end
        exp_q.push_back('{"coll_reclaim_0", 64'd0});
        bus_read(A_CLM, got);
        e = exp_q.pop_front(); n_checks++;
        if (got !== e.val) begin n_errors++; $display("FAIL %s: got=%h expected=%h", e.name, got, e.val); end
        bus_write(A_CMP, 64'd0);
    endtask

    task automatic test_async_reset;
        pulse_src(8'h07);
        exp_q.push_back('{"ar_claim_0", 64'd0});
        bus_read(A_CLM, got);
        e = exp_q.pop_front(); n_checks++;
        if (got !== e.val) begin n_errors++; $display("FAIL %s: got=%h expected=%h", e.name, got, e.val); end
        @(negedge clock);
        address = A_PEND; MemRead = 1'b1;
        exp_q.push_back('{"ar_pending_pre", 64'h6});
        #1 got = rdata;
        e = exp_q.pop_front(); n_checks++;
        if (got !== e.val) begin n_errors++; $display("FAIL %s: got=%h expected=%h", e.name, got, e.val); end
        #1 reset = 1'b1; irq_src = 8'h08;
        exp_q.push_back('{"ar_pending_now", 64'h0});
        #1 got = rdata;
        e = exp_q.pop_front(); n_checks++;
        if (got !== e.val) begin n_errors++; $display("FAIL %s: got=%h expected=%h", e.name, got, e.val); end
        exp_q.push_back('{"ar_irq_now", 64'd0});
        got = 64'(IRQ);
        e = exp_q.pop_front(); n_checks++;
        if (got !== e.val) begin n_errors++; $display("FAIL %s: got=%h expected=%h", e.name, got, e.val); end
        address = A_MASK;
        exp_q.push_back('{"ar_mask_now", 64'h0});
        #1 got = rdata;
        e = exp_q.pop_front(); n_checks++;
        if (got !== e.val) begin n_errors++; $display("FAIL %s: got=%h expected=%h", e.name, got, e.val); end
        MemRead = 1'b0; address = '0;
        @(negedge clock);
        reset = 1'b0;
        // irq_src[3] held through reset release latches once
        exp_q.push_back('{"ar_held_src_edge", 64'h8});
        bus_read(A_PEND, got);
        e = exp_q.pop_front(); n_checks++;
        if (got !== e.val) begin n_errors++; $display("FAIL %s: got=%h expected=%h", e.name, got, e.val); end
        exp_q.push_back('{"ar_claim_after", ONES});
        bus_read(A_CLM, got);
        e = exp_q.pop_front(); n_checks++;
        if (got !== e.val) begin n_errors++; $display("FAIL %s: got=%h expected=%h", e.name, got, e.val); end
        irq_src = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset    = 1'b1;
        irq_src  = '0;
        address  = '0;
        data     = '0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        test_reset;
        test_masked_w1c;
        test_timer_claim;
        test_priority;
        test_bad_complete;
        test_claim_set_collision;
        test_async_reset;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL scoreboard_drain: got=%0d expected=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
